edid_ddc_slave: RTL and testbench
=================================

Name: edid_ddc_slave

Overview:
- I2C/DDC responder for the HDMI sink port.
- Answers an upstream source's EDID reads at 7-bit address 0x50 from an external byte ROM.
- Sits beside the HDMI receive path, on the rx_scl/rx_sda pins through an open-drain pad. This block only ever pulls SDA low.
- Runs on the 50 MHz system clock and oversamples SCL/SDA. It never clocks on SCL.

Parameters:
- DEV_ADDR, 7'h50, 7-bit slave address for EDID data.
- SEG_ADDR, 7'h30, 7-bit E-DDC segment-pointer address (used only with the optional feature).
- FILT_LEN, 3, number of consecutive identical synchronized samples required before an SCL/SDA level change is accepted.

Ports:
- clk  input  1  system clock, 50 MHz.
- rstn  input  1  asynchronous active-low reset.
- scl_i  input  1  raw SCL from pad.
- sda_i  input  1  raw SDA from pad.
- sda_oe  output  1  1 = pad drives SDA low; 0 = released.
- rom_addr  output  9  EDID byte address; bit 8 = segment LSB.
- rom_data  input  8  ROM byte; valid 2 clk after rom_addr changes.
- busy  output  1  high from an addressed START until STOP.
- byte_sent  output  1  1-clk pulse per data byte sent and ACKed by the master.

Behaviour:
- Reset values: sda_oe=0, rom_addr=0, busy=0, byte_sent=0. Offset=0, segment=0, state IDLE. Filtered SCL/SDA reset to 1.
- Input conditioning:
  - Each line passes through a 2-FF synchronizer, then a FILT_LEN glitch filter.
  - Edge events (scl_rise, scl_fall, sda_rise, sda_fall) are 1-clk pulses derived from the filtered levels.
- Bus conditions:
  - START: sda_fall while filtered SCL=1.
  - STOP: sda_rise while filtered SCL=1.
  - START and STOP are recognised in every state, including mid-byte, and override the state machine.
  - START (also repeated START) -> ADDR with bit counter cleared.
  - STOP -> IDLE and busy=0.
- Sampling and driving:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, so the 3+FILT_LEN clk pipeline delay provides hold time.
- Bit order: all bytes are MSB first. The bit counter counts 0..7, then the 9th clock is the ACK slot.
- States:
  - IDLE: sda_oe=0; wait for START.
  - ADDR: shift 8 bits. After the 8th scl_rise, compare [7:1] with DEV_ADDR.
    - On match: go to ADDR_ACK and set busy=1.
    - On mismatch: go to IDLE. No ACK is driven, so the master sees NACK.
  - ADDR_ACK:
    - sda_oe=1 from the 8th scl_fall to the 9th scl_fall.
    - On the 9th scl_fall: R/W=0 -> OFFSET; R/W=1 -> RD_DATA.
    - On entry to RD_DATA, rom_data is loaded into the tx shift register and its MSB is driven (sda_oe = ~bit).
  - OFFSET: receive 8 bits; the offset register takes the byte on the 8th scl_rise. Then OFFSET_ACK (drive ACK), then WR_IGNORE.
  - WR_IGNORE: further written bytes are ACKed and discarded, because EDID is read-only. The offset is unchanged.
  - RD_DATA:
    - Shift out 8 bits, changing on each scl_fall.
    - After the 8th bit's scl_fall, sda_oe=0 and go to RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - ACK (SDA=0):
      - offset increments, wrapping 0xFF->0x00;
      - byte_sent pulses;
      - the next byte loads on scl_fall.
    - NACK: offset increments and byte_sent does not pulse. Go to IDLE and wait for STOP or START; SDA stays released.
- Address path: rom_addr = {segment[0], offset}. It is always registered.
- ROM timing: the offset changes on scl_rise and the load happens on a later scl_fall. That is at least half an SCL period, well beyond the 2-clk ROM latency.
- Reset mid-transfer: sda_oe drops to 0 immediately (asynchronously); all state clears.

Optional Feature:
- Macro: EDID_SEGMENT_PTR_EN.
- With the macro defined:
  - Address SEG_ADDR with W is ACKed.
  - The next byte is ACKed and written to an 8-bit segment register; further bytes are ACKed and ignored.
  - SEG_ADDR with R is NACKed.
  - Segment clears to 0 on STOP, per E-DDC.
  - rom_addr[8] = segment[0], which addresses a 512-byte EDID.
- Without the macro: SEG_ADDR is NACKed like any other foreign address, and rom_addr[8] is tied to 0.

Test Plan:
- Random read: START, 0xA0, 0x00, repeated START, 0xA1, read 3 bytes ACK/ACK/NACK, STOP. With ROM[n]=n^0x5A, expect 0x5A, 0x5B, 0x58. byte_sent pulses twice, busy drops after STOP, and the final offset is 3.
- Wrap: write offset 0xFE, then read 3 bytes -> ROM[0xFE], ROM[0xFF], ROM[0x00].
- Foreign address: START, 0x78 -> sda_oe stays 0 through the 9th clock and busy stays 0. A following valid 0xA1 read still works.
- Glitch and abort: a 1-clk SDA pulse while SCL is high (shorter than FILT_LEN) is ignored. A STOP injected at bit 4 of a read byte -> IDLE, sda_oe=0 within FILT_LEN+3 clk.
- Reset mid-read: assert rstn=0 while sda_oe=1 -> sda_oe=0 asynchronously. After release, offset=0 and a read returns ROM[0].
- With EDID_SEGMENT_PTR_EN: write 0x60, 0x01, then random read 0xA0, 0x10 / 0xA1 -> rom_addr=0x110. After STOP, a new read uses segment 0. Without the macro, 0x60 is NACKed.

Source files
------------

// File: rtl/edid_ddc_slave.sv
`default_nettype none
// ============================================================================
// edid_ddc_slave : DDC/I2C responder serving EDID bytes from an external ROM.
// Optional E-DDC segment pointer: define EDID_SEGMENT_PTR_EN.  Revision: 1.0
// ============================================================================
module edid_ddc_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter logic [6:0] SEG_ADDR = 7'h30,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [8:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy,
  output logic       byte_sent
);

  localparam int c_cnt_w = ($clog2(FILT_LEN) > 0) ? $clog2(FILT_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILT_LEN - 1);
`ifdef EDID_SEGMENT_PTR_EN
  localparam bit c_seg_en = 1'b1;
`else
  localparam bit c_seg_en = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, OFFSET, SEG_DATA, WR_ACK, WR_IGNORE, RD_DATA, RD_ACK, RD_NEXT
  } state_t;

  // Index 0 = SCL, index 1 = SDA
  logic [1:0]         r_sync0, r_sync1, r_filt, r_filt_q;
  logic [c_cnt_w-1:0] r_flt_cnt [2];

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [6:0] r_tx;
  logic [7:0] r_offset;
  logic [8:0] r_rom_addr;
  logic       r_rw, r_seg_sel, r_sda_oe, r_busy, r_byte_sent;

  logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_addr_hit, w_seg_hit, w_seg_bit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync0      <= 2'b11;
      r_sync1      <= 2'b11;
      r_filt       <= 2'b11;
      r_filt_q     <= 2'b11;
      r_flt_cnt[0] <= '0;
      r_flt_cnt[1] <= '0;
    end else begin
      r_sync0  <= {sda_i, scl_i};
      r_sync1  <= r_sync0;
      r_filt_q <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_filt[i]) begin
          r_flt_cnt[i] <= '0;
        end else if (r_flt_cnt[i] == c_cnt_max) begin
          r_filt[i]    <= r_sync1[i];
          r_flt_cnt[i] <= '0;
        end else begin
          r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_scl_rise = r_filt[0] & ~r_filt_q[0];
  assign w_scl_fall = ~r_filt[0] & r_filt_q[0];
  assign w_sda_rise = r_filt[1] & ~r_filt_q[1];
  assign w_sda_fall = ~r_filt[1] & r_filt_q[1];
  assign w_start    = w_sda_fall & r_filt[0];
  assign w_stop     = w_sda_rise & r_filt[0];

  // Byte as it stands once the current rising edge has been shifted in
  assign w_byte     = {r_shift, r_filt[1]};
  assign w_addr_hit = (w_byte[7:1] == DEV_ADDR);
  assign w_seg_hit  = c_seg_en && (w_byte[7:1] == SEG_ADDR) && !w_byte[0];

`ifdef EDID_SEGMENT_PTR_EN
  logic [7:0] r_segment;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_segment <= 8'h00;
    else if (w_stop)
      r_segment <= 8'h00;
    else if (!w_start && r_state == SEG_DATA && w_scl_rise && r_bit_cnt == 3'd7)
      r_segment <= w_byte;
  end
  assign w_seg_bit = r_segment[0];
`else
  assign w_seg_bit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ADDR;
    end else if (w_stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        ADDR:
          if (w_scl_rise && r_bit_cnt == 3'd7)
            w_state_nxt = (w_addr_hit || w_seg_hit) ? ADDR_ACK : IDLE;
        ADDR_ACK:
          if (w_scl_fall && r_sda_oe)
            w_state_nxt = r_seg_sel ? SEG_DATA : (r_rw ? RD_DATA : OFFSET);
        OFFSET, SEG_DATA, WR_IGNORE:
          if (w_scl_rise && r_bit_cnt == 3'd7) w_state_nxt = WR_ACK;
        WR_ACK:
          if (w_scl_fall && r_sda_oe) w_state_nxt = WR_IGNORE;
        RD_DATA:
          if (w_scl_fall && r_bit_cnt == 3'd7) w_state_nxt = RD_ACK;
        RD_ACK:
          if (w_scl_rise) w_state_nxt = r_filt[1] ? IDLE : RD_NEXT;
        RD_NEXT:
          if (w_scl_fall) w_state_nxt = RD_DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // In the ACK states r_sda_oe doubles as the phase flag: low until the 8th fall, high through the 9th
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_byte_sent <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_tx        <= 7'd0;
      r_rw        <= 1'b0;
      r_seg_sel   <= 1'b0;
      r_offset    <= 8'h00;
      r_rom_addr  <= 9'h000;
    end else begin
      r_byte_sent <= 1'b0;
      r_rom_addr  <= {w_seg_bit, r_offset};
      if (w_start) begin
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 3'd0;
      end else if (w_stop) begin
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ADDR, OFFSET, SEG_DATA, WR_IGNORE:
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == ADDR) begin
                  r_rw      <= w_byte[0];
                  r_seg_sel <= w_seg_hit;
                  if (w_addr_hit || w_seg_hit) r_busy <= 1'b1;
                end
                if (r_state == OFFSET) r_offset <= w_byte;
              end
            end
          ADDR_ACK, WR_ACK:
            if (w_scl_fall) begin
              r_bit_cnt <= 3'd0;
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else if (r_state == ADDR_ACK && r_rw) begin
                r_tx     <= rom_data[6:0];
                r_sda_oe <= ~rom_data[7];
              end else begin
                r_sda_oe <= 1'b0;
              end
            end
          RD_DATA:
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd7) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 3'd0;
              end else begin
                r_sda_oe  <= ~r_tx[6];
                r_tx      <= {r_tx[5:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          RD_ACK:
            if (w_scl_rise) begin
              r_offset    <= r_offset + 8'd1;
              r_byte_sent <= ~r_filt[1];
            end
          RD_NEXT:
            if (w_scl_fall) begin
              r_tx      <= rom_data[6:0];
              r_sda_oe  <= ~rom_data[7];
              r_bit_cnt <= 3'd0;
            end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rom_addr  = r_rom_addr;
  assign busy      = r_busy;
  assign byte_sent = r_byte_sent;

endmodule
`default_nettype wire

// File: tb/tb_edid_ddc_slave.sv
`default_nettype none
// tb_edid_ddc_slave : bit-banged I2C master against edid_ddc_slave, reads checked
// against an EDID ROM array and an offset/segment pointer model.
module tb_edid_ddc_slave;

  localparam int H    = 32;
  localparam int Q    = 16;
  localparam int FILT = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [8:0] rom_addr;
  logic [7:0] rom_data, rom_d1;
  logic       busy, byte_sent;

  logic [7:0] rom [512];
  int         n_pass  = 0;
  int         n_total = 0;
  int         bs_cnt  = 0;
  int         oe_cnt  = 0;
  logic [7:0] ref_off;
  logic [7:0] ref_seg;

  assign sda_bus = sda_m & ~sda_oe;

  edid_ddc_slave dut (
    .clk(clk), .rstn(rstn), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .byte_sent(byte_sent)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    rom_d1   <= rom[rom_addr];
    rom_data <= rom_d1;
  end

  always @(negedge clk) begin
    if (byte_sent === 1'b1) bs_cnt++;
    if (sda_oe === 1'b1) oe_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; wait_clk(Q); scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q); scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q); scl_m = 1'b1; wait_clk(Q); sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit glitch, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clk(Q); scl_m = 1'b1; wait_clk(H/2);
      if (glitch && i == 7 && b[i]) begin
        sda_m = 1'b0; wait_clk(1); sda_m = 1'b1;
      end
      wait_clk(H/2); scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1; wait_clk(H/2);
    ack = !sda_bus;
    wait_clk(H/2); scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic rd_byte(input bit nack, input int stop_at, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int p = 0; p < 8; p++) begin
      if (p == stop_at) begin
        sda_m = 1'b0; wait_clk(Q); scl_m = 1'b1; wait_clk(Q); sda_m = 1'b1;
        return;
      end
      wait_clk(Q); scl_m = 1'b1; wait_clk(H/2);
      b = {b[6:0], sda_bus};
      wait_clk(H/2); scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = nack; wait_clk(Q); scl_m = 1'b1; wait_clk(H); scl_m = 1'b0; wait_clk(Q);
    sda_m = 1'b1;
  endtask

  // Current-address read of n bytes (last one NACKed) after a START/rSTART, then STOP
  task automatic read_cur(input int n, input string tag);
    bit ack;
    logic [7:0] b, e;
    int bs0;
    wr_byte(8'hA1, 1'b0, ack);
    n_total++;
    if (ack !== 1'b1) $display("FAIL %s rd_addr_ack: got %b expected 1", tag, ack); else n_pass++;
    bs0 = bs_cnt;
    for (int i = 0; i < n; i++) begin
      e = rom[{ref_seg[0], ref_off}];
      rd_byte(i == n - 1, -1, b);
      n_total++;
      if (b !== e) $display("FAIL %s data[%0d]: got %h expected %h", tag, i, b, e); else n_pass++;
      ref_off = ref_off + 8'd1;
    end
    i2c_stop();
    ref_seg = 8'h00;
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s busy_after_stop: got %b expected 0", tag, busy); else n_pass++;
    n_total++;
    if (bs_cnt - bs0 != n - 1) $display("FAIL %s byte_sent_count: got %0d expected %0d", tag, bs_cnt - bs0, n - 1);
    else n_pass++;
    n_total++;
    if (rom_addr !== {ref_seg[0], ref_off})
      $display("FAIL %s final_rom_addr: got %h expected %h", tag, rom_addr, {ref_seg[0], ref_off});
    else n_pass++;
  endtask

  task automatic txn_read(input logic [7:0] off, input int n, input bit glitch, input string tag);
    bit ack;
    i2c_start();
    wr_byte(8'hA0, glitch, ack);
    n_total++;
    if (ack !== 1'b1) $display("FAIL %s wr_addr_ack: got %b expected 1", tag, ack); else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_addressed: got %b expected 1", tag, busy); else n_pass++;
    wr_byte(off, 1'b0, ack);
    n_total++;
    if (ack !== 1'b1) $display("FAIL %s offset_ack: got %b expected 1", tag, ack); else n_pass++;
    ref_off = off;
    i2c_rstart();
    read_cur(n, tag);
  endtask

  task automatic test_reset();
    rstn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    n_total++; if (sda_oe !== 1'b0) $display("FAIL reset sda_oe: got %b expected 0", sda_oe); else n_pass++;
    n_total++; if (rom_addr !== 9'h000) $display("FAIL reset rom_addr: got %h expected 000", rom_addr); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (byte_sent !== 1'b0) $display("FAIL reset byte_sent: got %b expected 0", byte_sent); else n_pass++;
    rstn = 1'b1;
    wait_clk(10);
    ref_off = 8'h00; ref_seg = 8'h00;
  endtask

  task automatic test_random_read();
    bit ack;
    logic [7:0] b;
    logic [7:0] exp_b [3];
    int bs0;
    exp_b[0] = 8'h5A; exp_b[1] = 8'h5B; exp_b[2] = 8'h58;
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rr addr_ack: got %b expected 1", ack); else n_pass++;
    wr_byte(8'h00, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rr offset_ack: got %b expected 1", ack); else n_pass++;
    i2c_rstart();
    wr_byte(8'hA1, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL rr read_addr_ack: got %b expected 1", ack); else n_pass++;
    bs0 = bs_cnt;
    for (int i = 0; i < 3; i++) begin
      rd_byte(i == 2, -1, b);
      n_total++;
      if (b !== exp_b[i]) $display("FAIL rr data[%0d]: got %h expected %h", i, b, exp_b[i]); else n_pass++;
    end
    n_total++; if (busy !== 1'b1) $display("FAIL rr busy_before_stop: got %b expected 1", busy); else n_pass++;
    i2c_stop();
    n_total++; if (busy !== 1'b0) $display("FAIL rr busy_after_stop: got %b expected 0", busy); else n_pass++;
    n_total++; if (bs_cnt - bs0 != 2) $display("FAIL rr byte_sent_count: got %0d expected 2", bs_cnt - bs0); else n_pass++;
    n_total++; if (rom_addr !== 9'h003) $display("FAIL rr final_offset: got %h expected 003", rom_addr); else n_pass++;
    ref_off = 8'h03;
  endtask

  task automatic test_wrap();
    txn_read(8'hFE, 3, 1'b0, "wrap");
  endtask

  task automatic test_foreign();
    bit ack;
    int oe0;
    logic [6:0] a;
    oe0 = oe_cnt;
    i2c_start();
    wr_byte(8'h78, 1'b0, ack);
    n_total++; if (ack !== 1'b0) $display("FAIL foreign ack: got %b expected 0", ack); else n_pass++;
    n_total++; if (oe_cnt != oe0) $display("FAIL foreign sda_oe_cycles: got %0d expected 0", oe_cnt - oe0); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL foreign busy: got %b expected 0", busy); else n_pass++;
    i2c_rstart();
    read_cur(2, "after_foreign");
    for (int k = 0; k < 2; k++) begin
      a = 7'($urandom_range(0, 127));
      while (a == 7'h50 || a == 7'h30) a = 7'($urandom_range(0, 127));
      i2c_start();
      wr_byte({a, 1'($urandom_range(0, 1))}, 1'b0, ack);
      n_total++; if (ack !== 1'b0) $display("FAIL foreign_rand %h ack: got %b expected 0", a, ack); else n_pass++;
      i2c_stop();
    end
  endtask

  task automatic test_write_ignore();
    bit ack;
    logic [7:0] off;
    off = 8'($urandom);
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL wig addr_ack: got %b expected 1", ack); else n_pass++;
    wr_byte(off, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL wig offset_ack: got %b expected 1", ack); else n_pass++;
    ref_off = off;
    for (int k = 0; k < 2; k++) begin
      wr_byte(8'($urandom), 1'b0, ack);
      n_total++; if (ack !== 1'b1) $display("FAIL wig extra_ack[%0d]: got %b expected 1", k, ack); else n_pass++;
    end
    i2c_stop();
    i2c_start();
    read_cur(2, "wig");
  endtask

  task automatic test_glitch_abort();
    bit ack;
    logic [7:0] o, b;
    txn_read(8'($urandom), 2, 1'b1, "glitch");
    // The abort bit must be released by the slave so the master's STOP is visible
    o = 8'($urandom);
    while (rom[{1'b0, o}][3] != 1'b1) o = 8'($urandom);
    i2c_start();
    wr_byte(8'hA0, 1'b0, ack);
    wr_byte(o, 1'b0, ack);
    i2c_rstart();
    wr_byte(8'hA1, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL abort addr_ack: got %b expected 1", ack); else n_pass++;
    rd_byte(1'b0, 4, b);
    wait_clk(FILT + 4);
    n_total++; if (sda_oe !== 1'b0) $display("FAIL abort sda_oe: got %b expected 0", sda_oe); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL abort busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (rom_addr !== {1'b0, o}) $display("FAIL abort offset: got %h expected %h", rom_addr, {1'b0, o}); else n_pass++;
    ref_off = o; ref_seg = 8'h00;
    wait_clk(H);
    i2c_start();
    read_cur(1, "after_abort");
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    a = 8'hA1;
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      sda_m = a[i]; wait_clk(Q); scl_m = 1'b1; wait_clk(H); scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1; wait_clk(H/2);
    n_total++; if (sda_oe !== 1'b1) $display("FAIL rstmid ack_driven: got %b expected 1", sda_oe); else n_pass++;
    rstn = 1'b0;
    #2;
    n_total++; if (sda_oe !== 1'b0) $display("FAIL rstmid async_release: got %b expected 0", sda_oe); else n_pass++;
    wait_clk(2);
    rstn = 1'b1;
    wait_clk(4);
    n_total++; if (rom_addr !== 9'h000) $display("FAIL rstmid rom_addr: got %h expected 000", rom_addr); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid busy: got %b expected 0", busy); else n_pass++;
    scl_m = 1'b0; wait_clk(Q);
    i2c_stop();
    ref_off = 8'h00; ref_seg = 8'h00;
    i2c_start();
    read_cur(2, "rstmid_read");
  endtask

  task automatic test_segment();
    bit ack;
`ifdef EDID_SEGMENT_PTR_EN
    logic [7:0] b;
    i2c_start();
    wr_byte(8'h60, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL seg addr_ack: got %b expected 1", ack); else n_pass++;
    wr_byte(8'h01, 1'b0, ack);
    n_total++; if (ack !== 1'b1) $display("FAIL seg data_ack: got %b expected 1", ack); else n_pass++;
    ref_seg = 8'h01;
    i2c_rstart();
    wr_byte(8'hA0, 1'b0, ack);
    wr_byte(8'h10, 1'b0, ack);
    ref_off = 8'h10;
    i2c_rstart();
    n_total++; if (rom_addr !== 9'h110) $display("FAIL seg rom_addr: got %h expected 110", rom_addr); else n_pass++;
    wr_byte(8'hA1, 1'b0, ack);
    rd_byte(1'b1, -1, b);
    n_total++;
    if (b !== rom[{ref_seg[0], ref_off}]) $display("FAIL seg data: got %h expected %h", b, rom[{ref_seg[0], ref_off}]);
    else n_pass++;
    ref_off = ref_off + 8'd1;
    i2c_stop();
    ref_seg = 8'h00;
    n_total++; if (rom_addr !== 9'h011) $display("FAIL seg cleared_by_stop: got %h expected 011", rom_addr); else n_pass++;
    i2c_start();
    read_cur(1, "seg_after_stop");
    i2c_start();
    wr_byte(8'h61, 1'b0, ack);
    n_total++; if (ack !== 1'b0) $display("FAIL seg read_nack: got %b expected 0", ack); else n_pass++;
    i2c_stop();
`else
    i2c_start();
    wr_byte(8'h60, 1'b0, ack);
    n_total++; if (ack !== 1'b0) $display("FAIL seg nack_disabled: got %b expected 0", ack); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL seg busy_disabled: got %b expected 0", busy); else n_pass++;
    i2c_stop();
    n_total++; if (rom_addr[8] !== 1'b0) $display("FAIL seg addr_msb: got %b expected 0", rom_addr[8]); else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++)
      txn_read(8'($urandom), int'($urandom_range(1, 4)), 1'b0, "random");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
    for (int i = 256; i < 512; i++) rom[i] = 8'($urandom);
    test_reset();
    test_random_read();
    test_wrap();
    test_foreign();
    test_write_ignore();
    test_glitch_abort();
    test_reset_mid();
    test_segment();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
